// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between an ALU (A) and a load (B)
// writeback requester, each with a one-entry holding buffer and a registered write stage.
module regfile_wb_arbiter #(
  parameter int unsigned RR_EN = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_reg,
  input  logic [31:0]      a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_reg,
  input  logic [31:0]      b_data,
  output logic             Reg_Write,
  output logic [4:0]       Write_Register,
  output logic [31:0]      Write_Data,
  input  logic [4:0]       query_reg,
  output logic             query_hit,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {SIDE_A, SIDE_B} side_t;

  localparam bit RR = (RR_EN != 0);

  side_t       last_grant;
  logic        a_full, b_full;
  logic [4:0]  a_reg_q, b_reg_q;
  logic [31:0] a_data_q, b_data_q;
  logic        grant_a, grant_b, both_full;
  logic        a_acc, b_acc;

  // Grant depends only on buffer occupancy and the pointer, never on incoming valids.
  always_comb begin
    both_full = a_full & b_full;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (a_full && (!b_full || !RR || last_grant == SIDE_B))
      grant_a = 1'b1;
    else if (b_full)
      grant_b = 1'b1;
  end

  assign a_ready = !a_full | grant_a;
  assign b_ready = !b_full | grant_b;
  assign a_acc   = a_valid & a_ready;
  assign b_acc   = b_valid & b_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_full   <= 1'b0;
      a_reg_q  <= '0;
      a_data_q <= '0;
    end else if (a_acc) begin
      a_full   <= 1'b1;
      a_reg_q  <= a_reg;
      a_data_q <= a_data;
    end else if (grant_a) begin
      a_full   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_full   <= 1'b0;
      b_reg_q  <= '0;
      b_data_q <= '0;
    end else if (b_acc) begin
      b_full   <= 1'b1;
      b_reg_q  <= b_reg;
      b_data_q <= b_data;
    end else if (grant_b) begin
      b_full   <= 1'b0;
    end
  end

  // r0 writes still consume the grant and update address/data; only the enable is suppressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Reg_Write      <= 1'b0;
      Write_Register <= '0;
      Write_Data     <= '0;
      last_grant     <= SIDE_B;
    end else if (grant_a) begin
      Reg_Write      <= (a_reg_q != '0);
      Write_Register <= a_reg_q;
      Write_Data     <= a_data_q;
      last_grant     <= SIDE_A;
    end else if (grant_b) begin
      Reg_Write      <= (b_reg_q != '0);
      Write_Register <= b_reg_q;
      Write_Data     <= b_data_q;
      last_grant     <= SIDE_B;
    end else begin
      Reg_Write      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      conflict_cnt <= '0;
    else if (both_full && conflict_cnt != '1)
      conflict_cnt <= conflict_cnt + CNT_W'(1);
  end

  assign query_hit = (query_reg != '0) &&
                     ((a_full && a_reg_q == query_reg) ||
                      (b_full && b_reg_q == query_reg) ||
                      (Reg_Write && Write_Register == query_reg));

endmodule
